booth_mul_seq_ctrl: RTL

//   Sequential radix-4 Booth multiplier controller: iterates a single booth_decoder instance over the
//   8 Booth digits of a signed 16-bit multiplier, accumulating one 17-bit partial product per cycle

---
 rtl/booth_mul_seq_ctrl_pkg.sv | 24 ++
 rtl/booth_mul_seq_ctrl_booth.sv | 36 +++
 rtl/booth_mul_seq_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/booth_mul_seq_ctrl_pkg.sv
// Shared types and sizes for the sequential radix-4 Booth multiplier.
package booth_mul_seq_ctrl_pkg;

  localparam int OP_W     = 16;
  localparam int PP_W     = 17;
  localparam int RES_W    = 32;
  localparam int N_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Booth triplet {x[2k+1], x[2k], x[2k-1]} with x[-1] = 0.
  function automatic logic [2:0] booth_triplet(input logic [OP_W-1:0] x, input logic [2:0] k);
    logic [OP_W:0] xe;
    int            idx;
    xe  = {x, 1'b0};
    idx = 2 * int'(k);
    return xe[idx +: 3];
  endfunction

endpackage

// File: rtl/booth_mul_seq_ctrl_booth.sv
// Booth digit encoder and partial-product decoder used by the multiplier controller.
module booth_digit_encoder (
  input  logic [2:0] triplet_i,
  output logic       single_o,
  output logic       double_o,
  output logic       negative_o
);
  // triplet_i = {x1, x0, x_1}
  assign single_o   = triplet_i[1] ^ triplet_i[0];
  assign double_o   = (triplet_i[2] & ~triplet_i[1] & ~triplet_i[0]) |
                      (~triplet_i[2] & triplet_i[1] & triplet_i[0]);
  assign negative_o = triplet_i[2];
endmodule

// The partial product is returned in one's-complement form when negative; the
// caller adds negative_i as the +1. This keeps -2 * (-32768) = +65536 exact,
// which a 17-bit two's-complement PP could not represent.
module booth_decoder
  import booth_mul_seq_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] y_i,
  input  logic            single_i,
  input  logic            double_i,
  input  logic            negative_i,
  output logic [PP_W-1:0] pp_o
);
  logic [PP_W-1:0] mag;

  // Select 0, Y or 2Y, then conditionally invert.
  always_comb begin
    mag = '0;
    if (single_i)      mag = {y_i[OP_W-1], y_i};
    else if (double_i) mag = {y_i, 1'b0};
    pp_o = mag ^ {PP_W{negative_i}};
  end
endmodule

// File: rtl/booth_mul_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller: one Booth digit per BUSY cycle.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for an operand pair
// ST_BUSY | accumulating partial product for digit k_q
// ST_DONE | res_o valid, held until the consumer takes it
module booth_mul_seq_ctrl
  import booth_mul_seq_ctrl_pkg::*;
#(
  parameter int TRUNC_DIGITS = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OP_W-1:0]   mcand_i,
  input  logic [OP_W-1:0]   mplier_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [RES_W-1:0]  res_o,
  output logic              busy_o
);

  if (TRUNC_DIGITS < 0 || TRUNC_DIGITS > N_DIGITS - 1) begin : g_bad_trunc
    $error("booth_mul_seq_ctrl: TRUNC_DIGITS must be in 0..7");
  end

  localparam logic [2:0] K_START = 3'(TRUNC_DIGITS);
  localparam logic [2:0] K_LAST  = 3'(N_DIGITS - 1);

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [OP_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]   mplier_q, mplier_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [RES_W-1:0]  res_q, res_d;

  logic [2:0]        triplet;
  logic              sel_single, sel_double, sel_neg;
  logic [PP_W-1:0]   pp;
  logic [RES_W-1:0]  pp_term;
  logic [RES_W-1:0]  acc_sum;
  logic              accept;

  assign triplet = booth_triplet(mplier_q, k_q);

  booth_digit_encoder u_enc (
    .triplet_i  (triplet),
    .single_o   (sel_single),
    .double_o   (sel_double),
    .negative_o (sel_neg)
  );

  booth_decoder u_dec (
    .y_i        (mcand_q),
    .single_i   (sel_single),
    .double_i   (sel_double),
    .negative_i (sel_neg),
    .pp_o       (pp)
  );

  // Sign-extended PP plus the deferred +1, weighted by 4^k.
  always_comb begin
    pp_term = ({{(RES_W-PP_W){pp[PP_W-1]}}, pp} + {{(RES_W-1){1'b0}}, sel_neg}) << {k_q, 1'b0};
    acc_sum = acc_q + pp_term;
  end

  assign in_ready_o  = ((state_q == ST_IDLE) | ((state_q == ST_DONE) & res_ready_i)) & ~rst_i;
  assign accept      = in_valid_i & in_ready_o;
  assign res_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_BUSY);
  assign res_o       = res_q;

  // Next-state, operand capture and accumulation.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    res_d    = res_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mcand_d  = mcand_i;
          mplier_d = mplier_i;
          acc_d    = '0;
          k_d      = K_START;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d = acc_sum;
        if (k_q == K_LAST) begin
          res_d   = acc_sum;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      ST_DONE: begin
        if (res_ready_i) begin
          if (accept) begin
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            acc_d    = '0;
            k_d      = K_START;
            state_d  = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      k_q      <= K_START;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
    end
  end

endmodule
